// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-stage program-counter unit.
package pc_gen_pkg;

    localparam int unsigned DEFAULT_INSN_BYTES = 4;
    localparam int unsigned ADDR_MAX           = 64;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_BRANCH,
        SRC_TRAP
    } redirect_src_t;

    // Clears the low align_bits of an address of up to ADDR_MAX bits.
    function automatic logic [ADDR_MAX-1:0] align_addr(input logic [ADDR_MAX-1:0] addr,
                                                       input int unsigned        align_bits);
        logic [ADDR_MAX-1:0] mask;
        mask = (ADDR_MAX'(1) << align_bits) - ADDR_MAX'(1);
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch handshake between pc_gen (master) and instruction fetch (slave).
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] pc_out;
    logic            flush;

    modport master (output fetch_valid, output pc_out, output flush, input fetch_ready);
    modport slave  (input fetch_valid, input pc_out, input flush, output fetch_ready);
endinterface

// File: rtl/pc_redirect_latch.sv
// Holds one redirect that arrived during a stall; a trap is never displaced by a branch.
module pc_redirect_latch
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            capture,
    input  logic            clear,
    input  logic            trap_req,
    input  logic            br_req,
    input  logic [XLEN-1:0] trap_vector,
    input  logic [XLEN-1:0] branch_address,
    output redirect_src_t   src,
    output logic [XLEN-1:0] target
);

    // NOTE: only src is reset; target is meaningless while src is SRC_NONE.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            src <= SRC_NONE;
        end else if (capture) begin
            if (trap_req) begin
                src    <= SRC_TRAP;
                target <= trap_vector;
            end else if (br_req && src != SRC_TRAP) begin
                src    <= SRC_BRANCH;
                target <= branch_address;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC unit: trap > pending > branch > sequential, flush pulse on redirect.
// Define MISALIGN_TRAP_EN to halt fetch on misaligned branch targets instead of aligning them.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INSN_BYTES   = DEFAULT_INSN_BYTES,
    parameter int unsigned     ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            is_call,
    input  logic            is_auipc,
    input  logic            should_branch,
    input  logic [XLEN-1:0] branch_address,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vector,
    pc_gen_if.master        fetch,
    output logic            misalign_err,
    output logic [XLEN-1:0] misalign_addr
);

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
        return XLEN'(align_addr(ADDR_MAX'(a), ALIGN_BITS));
    endfunction

    logic            br_req;
    logic            fire;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q;
    logic            flush_q, flush_d;
    redirect_src_t   pend_src;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] trap_tgt;

    assign br_req   = is_call | is_auipc | should_branch;
    assign fire     = valid_q & fetch.fetch_ready & ~stall;
    assign br_tgt   = (pend_src == SRC_BRANCH) ? pend_target : branch_address;
    assign trap_tgt = trap_req ? trap_vector : pend_target;

    // Latch is consumed (or superseded by a live trap) on any unstalled edge.
    pc_redirect_latch #(.XLEN(XLEN)) u_latch (
        .clk            (clk),
        .rst            (rst),
        .capture        (stall),
        .clear          (~stall),
        .trap_req       (trap_req),
        .br_req         (br_req),
        .trap_vector    (trap_vector),
        .branch_address (branch_address),
        .src            (pend_src),
        .target         (pend_target)
    );

`ifdef MISALIGN_TRAP_EN
    logic            halt_q, halt_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pc_d    = pc_q;
        flush_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
        halt_d  = halt_q;
        err_d   = 1'b0;
        maddr_d = maddr_q;
`endif
        if (!stall) begin
            if (trap_req || pend_src == SRC_TRAP) begin
                pc_d    = align(trap_tgt);
                flush_d = 1'b1;
`ifdef MISALIGN_TRAP_EN
                halt_d  = 1'b0;
`endif
            end else if (pend_src == SRC_BRANCH || br_req) begin
`ifdef MISALIGN_TRAP_EN
                if (!halt_q) begin
                    if (align(br_tgt) != br_tgt) begin
                        halt_d  = 1'b1;
                        err_d   = 1'b1;
                        maddr_d = br_tgt;
                    end else begin
                        pc_d    = br_tgt;
                        flush_d = 1'b1;
                    end
                end
`else
                pc_d    = align(br_tgt);
                flush_d = 1'b1;
`endif
            end else if (fire) begin
                pc_d = pc_q + XLEN'(INSN_BYTES);
            end
        end
    end

    // NOTE: synchronous reset inside the clocked block; all state uses non-blocking assignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
            maddr_q <= '0;
`endif
        end else begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
`ifdef MISALIGN_TRAP_EN
            halt_q  <= halt_d;
            err_q   <= err_d;
            maddr_q <= maddr_d;
            valid_q <= ~halt_d;
`else
            valid_q <= 1'b1;
`endif
        end
    end

    assign fetch.pc_out      = pc_q;
    assign fetch.fetch_valid = valid_q;
    assign fetch.flush       = flush_q;

`ifdef MISALIGN_TRAP_EN
    assign misalign_err  = err_q;
    assign misalign_addr = maddr_q;
`else
    assign misalign_err  = 1'b0;
    assign misalign_addr = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver queues per-edge expectations, monitor checks them.
module tb_pc_gen;

    typedef struct {
        string       tag;
        logic [66:0] v;   // {fetch_valid, pc_out, flush, misalign_err, misalign_addr}
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        is_call = 1'b0, is_auipc = 1'b0, should_branch = 1'b0;
    logic [31:0] branch_address = '0;
    logic        trap_req = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        misalign_err;
    logic [31:0] misalign_addr;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    pc_gen_if #(.XLEN(32)) fetch_if ();

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h100),
        .INSN_BYTES   (4),
        .ALIGN_BITS   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .is_call        (is_call),
        .is_auipc       (is_auipc),
        .should_branch  (should_branch),
        .branch_address (branch_address),
        .trap_req       (trap_req),
        .trap_vector    (trap_vector),
        .fetch          (fetch_if),
        .misalign_err   (misalign_err),
        .misalign_addr  (misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [66:0] got, input logic [66:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got v=%b pc=%h fl=%b err=%b ma=%h, want v=%b pc=%h fl=%b err=%b ma=%h",
                     name, got[66], got[65:34], got[33], got[32], got[31:0],
                     want[66], want[65:34], want[33], want[32], want[31:0]);
        end
    endtask

    // Monitor: compares DUT outputs 1 ns after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.tag, {fetch_if.fetch_valid, fetch_if.pc_out, fetch_if.flush,
                              misalign_err, misalign_addr}, e.v);
            end
        end
    end

    // br3 = {is_call, is_auipc, should_branch}
    task automatic cyc(input string tag, input logic r, input logic s, input logic [2:0] br3,
                       input logic [31:0] ba, input logic tr, input logic [31:0] tv,
                       input logic rdy, input logic ev, input logic [31:0] epc,
                       input logic efl, input logic eerr, input logic [31:0] emad);
        exp_t e;
        @(negedge clk);
        rst = r;
        stall = s;
        {is_call, is_auipc, should_branch} = br3;
        branch_address = ba;
        trap_req = tr;
        trap_vector = tv;
        fetch_if.fetch_ready = rdy;
        e.tag = tag;
        e.v   = {ev, epc, efl, eerr, emad};
        sb.push_back(e);
        @(posedge clk);
    endtask

    logic [31:0] mad;
    logic        mis_en;

    initial begin
        fetch_if.fetch_ready = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis_en = 1'b1;
        mad    = 32'h2002;
`else
        mis_en = 1'b0;
        mad    = 32'h0;
`endif
        //   tag           rst st br3     ba            tr tv          rdy ev  pc            fl err ma
        cyc("reset0",      1, 0, 3'b000, 32'h0,       0, 32'h0,      1,  0, 32'h100,      0, 0, 0);
        cyc("reset1",      1, 0, 3'b000, 32'h0,       0, 32'h0,      1,  0, 32'h100,      0, 0, 0);
        cyc("first_valid", 0, 0, 3'b000, 32'h0,       0, 32'h0,      1,  1, 32'h100,      0, 0, 0);
        cyc("seq104",      0, 0, 3'b000, 32'h0,       0, 32'h0,      1,  1, 32'h104,      0, 0, 0);
        cyc("seq108",      0, 0, 3'b000, 32'h0,       0, 32'h0,      1,  1, 32'h108,      0, 0, 0);
        cyc("branch",      0, 0, 3'b001, 32'h2000,    0, 32'h0,      0,  1, 32'h2000,     1, 0, 0);
        cyc("bp_hold0",    0, 0, 3'b000, 32'h0,       0, 32'h0,      0,  1, 32'h2000,     0, 0, 0);
        cyc("bp_hold1",    0, 0, 3'b000, 32'h0,       0, 32'h0,      0,  1, 32'h2000,     0, 0, 0);
        cyc("stall_call",  0, 1, 3'b100, 32'h3000,    0, 32'h0,      1,  1, 32'h2000,     0, 0, 0);
        cyc("stall_trap",  0, 1, 3'b000, 32'h0,       1, 32'h80,     1,  1, 32'h2000,     0, 0, 0);
        cyc("stall_br",    0, 1, 3'b001, 32'h4000,    0, 32'h0,      1,  1, 32'h2000,     0, 0, 0);
        cyc("pend_trap",   0, 0, 3'b000, 32'h0,       0, 32'h0,      0,  1, 32'h80,       1, 0, 0);
        cyc("after_pend",  0, 0, 3'b000, 32'h0,       0, 32'h0,      1,  1, 32'h84,       0, 0, 0);
        cyc("stall_br_a",  0, 1, 3'b001, 32'h5000,    0, 32'h0,      1,  1, 32'h84,       0, 0, 0);
        cyc("stall_br_b",  0, 1, 3'b100, 32'h6000,    0, 32'h0,      1,  1, 32'h84,       0, 0, 0);
        cyc("pend_beats",  0, 0, 3'b010, 32'h7000,    0, 32'h0,      0,  1, 32'h6000,     1, 0, 0);
        cyc("seq6004",     0, 0, 3'b000, 32'h0,       0, 32'h0,      1,  1, 32'h6004,     0, 0, 0);
        cyc("trap_auipc",  0, 0, 3'b010, 32'h9000,    1, 32'h180,    1,  1, 32'h180,      1, 0, 0);
        cyc("seq184",      0, 0, 3'b000, 32'h0,       0, 32'h0,      1,  1, 32'h184,      0, 0, 0);
        cyc("stall_br_c",  0, 1, 3'b001, 32'hA000,    0, 32'h0,      1,  1, 32'h184,      0, 0, 0);
        cyc("live_trap",   0, 0, 3'b000, 32'h0,       1, 32'h300,    0,  1, 32'h300,      1, 0, 0);
        cyc("pend_gone",   0, 0, 3'b000, 32'h0,       0, 32'h0,      1,  1, 32'h304,      0, 0, 0);
        cyc("to_top",      0, 0, 3'b001, 32'hFFFFFFFC,0, 32'h0,      0,  1, 32'hFFFFFFFC, 1, 0, 0);
        cyc("wrap",        0, 0, 3'b000, 32'h0,       0, 32'h0,      1,  1, 32'h0,        0, 0, 0);
        cyc("after_wrap",  0, 0, 3'b000, 32'h0,       0, 32'h0,      1,  1, 32'h4,        0, 0, 0);
        cyc("trap_align",  0, 0, 3'b000, 32'h0,       1, 32'h403,    0,  1, 32'h400,      1, 0, 0);
        cyc("seq404",      0, 0, 3'b000, 32'h0,       0, 32'h0,      1,  1, 32'h404,      0, 0, 0);
        if (mis_en) begin
            cyc("misalign",    0, 0, 3'b001, 32'h2002, 0, 32'h0,  0,  0, 32'h404, 0, 1, mad);
            cyc("halt_hold",   0, 0, 3'b000, 32'h0,    0, 32'h0,  0,  0, 32'h404, 0, 0, mad);
            cyc("halt_ign_br", 0, 0, 3'b001, 32'h5000, 0, 32'h0,  1,  0, 32'h404, 0, 0, mad);
        end else begin
            cyc("align_br",    0, 0, 3'b001, 32'h2002, 0, 32'h0,  0,  1, 32'h2000, 1, 0, mad);
            cyc("align_hold",  0, 0, 3'b000, 32'h0,    0, 32'h0,  0,  1, 32'h2000, 0, 0, mad);
            cyc("br5000",      0, 0, 3'b001, 32'h5000, 0, 32'h0,  1,  1, 32'h5000, 1, 0, mad);
        end
        cyc("trap_restore",0, 0, 3'b000, 32'h0,       1, 32'h80,     0,  1, 32'h80,       1, 0, mad);
        cyc("seq84",       0, 0, 3'b000, 32'h0,       0, 32'h0,      1,  1, 32'h84,       0, 0, mad);
        cyc("stall_br_d",  0, 1, 3'b001, 32'hB000,    0, 32'h0,      1,  1, 32'h84,       0, 0, mad);
        cyc("mid_reset",   1, 0, 3'b000, 32'h0,       0, 32'h0,      0,  0, 32'h100,      0, 0, 0);
        cyc("no_pend",     0, 0, 3'b000, 32'h0,       0, 32'h0,      0,  1, 32'h100,      0, 0, 0);
        cyc("seq_again",   0, 0, 3'b000, 32'h0,       0, 32'h0,      1,  1, 32'h104,      0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Next-generation program-counter unit for the fetch stage.
- Owns the PC register and its reset vector.
- Selects the next PC by priority: trap > control-flow redirect (call / auipc / branch) > sequential.
- Holds redirects that arrive during a stall.
- Presents the PC to instruction fetch through a valid/ready handshake, with a one-cycle flush pulse whenever the PC is redirected.

Parameters:
- XLEN, 32, PC and address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset (XLEN bits).
- INSN_BYTES, 4, sequential PC increment.
- ALIGN_BITS, 2, number of low address bits that must be zero in any fetch address.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  pipeline hold; no PC change while high, except via the pending latch rules
- is_call  in  1  redirect request: call/jump
- is_auipc  in  1  redirect request: auipc-style PC load
- should_branch  in  1  redirect request: taken branch
- branch_address  in  XLEN  target for call/auipc/branch redirects
- trap_req  in  1  trap/exception redirect, highest priority
- trap_vector  in  XLEN  trap target address
- fetch_ready  in  1  fetch accepts pc_out this cycle
- fetch_valid  out  1  pc_out is a valid fetch address
- pc_out  out  XLEN  current fetch PC
- flush  out  1  one-cycle pulse; the PC was redirected on the previous edge
- misalign_err  out  1  one-cycle pulse (MISALIGN_TRAP_EN only; tied 0 otherwise)
- misalign_addr  out  XLEN  offending target (MISALIGN_TRAP_EN only; tied 0 otherwise)

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - pc_out=RESET_VECTOR, fetch_valid=0, flush=0, pending latch cleared, misalign_err=0, misalign_addr=0.
  - fetch_valid rises on the first edge with rst=0.
  - Reset mid-operation discards any pending redirect.
- Signal definitions:
  - br_req = is_call | is_auipc | should_branch.
  - fire = fetch_valid & fetch_ready & ~stall.
- Priority each edge, with stall=0:
  1. trap_req: pc <= trap_vector, flush<=1.
  2. else pending latch valid: pc <= pending target, flush<=1, latch cleared.
  3. else br_req: pc <= branch_address, flush<=1.
  4. else fire: pc <= pc + INSN_BYTES, flush<=0.
  5. else: pc holds, flush<=0.
- Redirects do not require fetch_ready. An unaccepted fetch at the old PC is abandoned.
- Live request vs. pending latch: a live trap_req beats the pending latch. A live br_req in the same cycle as a valid pending latch is dropped; the pending target is older-but-committed, and the execute stage re-issues.
- Stall=1:
  - PC and fetch_valid hold; flush<=0.
  - trap_req or br_req is captured into the pending latch (target + source).
  - A trap overwrites a pending branch. A branch never overwrites a pending trap. A newer branch overwrites an older pending branch.
- Latency:
  - A redirect sampled at edge N appears on pc_out after edge N, with flush=1 for that cycle.
  - A stalled redirect appears after the first edge with stall=0.
- Arithmetic:
  - pc + INSN_BYTES wraps modulo 2^XLEN; no overflow flag.
  - Without MISALIGN_TRAP_EN, the low ALIGN_BITS of every loaded target (branch, trap, pending) are forced to 0.
- Simultaneous trap_req and br_req: trap wins; the branch is discarded, both live and when latching.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A branch/pending target with nonzero low ALIGN_BITS is not loaded.
  - misalign_err pulses 1 cycle and misalign_addr captures the target.
  - fetch_valid<=0 and the PC holds until the next trap_req, which loads trap_vector and restores fetch_valid=1.
  - Trap targets are still force-aligned.
- Undefined: silent alignment as above; misalign_err and misalign_addr are constant 0.

Decomposition:
- Package pc_gen_pkg holds:
  - enum redirect_src_t {SRC_NONE, SRC_BRANCH, SRC_TRAP};
  - function align_addr(addr) clearing ALIGN_BITS;
  - default INSN_BYTES.
- One sub-module: pc_redirect_latch (pending target + redirect_src_t, overwrite-priority logic, clear input).

Test Plan:
- Reset and sequential: rst for 2 cycles, RESET_VECTOR=32'h100 -> pc_out=32'h100, fetch_valid=0 during reset; with fetch_ready=1, pc_out sequence is 100, 104, 108; flush=0 throughout.
- Branch and backpressure:
  - should_branch=1, branch_address=32'h2000, fetch_ready=0 -> next cycle pc_out=32'h2000, flush=1 for exactly 1 cycle.
  - fetch_ready=0 thereafter -> PC holds at 32'h2000.
- Stalled redirect:
  - stall=1 for 3 cycles; is_call with 32'h3000 in cycle 1, trap_req with 32'h80 in cycle 2, should_branch with 32'h4000 in cycle 3.
  - Required: PC holds through the stall; after stall drops, pc_out=32'h80 with flush=1, and 32'h4000 is never fetched.
- Trap priority and wrap:
  - trap_req and is_auipc in the same cycle -> pc_out=trap_vector.
  - Separately, pc=32'hFFFF_FFFC with fire -> pc_out=32'h0.
- Alignment: branch_address=32'h2002.
  - Without MISALIGN_TRAP_EN -> pc_out=32'h2000.
  - With MISALIGN_TRAP_EN -> misalign_err=1 for 1 cycle, misalign_addr=32'h2002, fetch_valid=0 until trap_req with 32'h80 -> pc_out=32'h80, fetch_valid=1.
